// File: rtl/ex_muldiv.sv
// ex_muldiv: execute-stage RV32M unit.
// Iterative shift-add multiply and restoring divide.
module ex_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     inst_i,
    input  logic [31:0]     inst_addr_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            reg_wen_i,
    input  logic            flush_i,
    output logic [XLEN-1:0] rd_data_o,
    output logic [4:0]      rd_addr_o,
    output logic            reg_wen_o,
    output logic            hold_o,
    output logic            busy_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_nxt;

    logic [2:0]  r_f3;
    logic [4:0]  r_rd;
    logic [31:0] r_b;
    logic        r_neg;
    logic        r_negr;
    logic [63:0] r_acc;
    logic [4:0]  r_cnt;

    logic        w_is_m;
    logic [2:0]  w_f3;
    logic        w_sa;
    logic        w_sb;
    logic        w_dz;
    logic        w_accept;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_next;
    logic [32:0] w_div_hi;
    logic        w_div_ge;
    logic [31:0] w_div_sub;
    logic [63:0] w_div_next;
    logic [63:0] w_p;
    logic [31:0] w_q;
    logic [31:0] w_r;
    logic [31:0] w_res;
    logic        w_unused;

    assign w_unused = ^{inst_addr_i, inst_i[24:15], inst_i[11:7]};

    assign w_is_m = (inst_i[6:0] == 7'b0110011)
                  & (inst_i[31:25] == 7'b0000001)
                  & reg_wen_i;
    assign w_f3 = inst_i[14:12];
    assign w_accept = (r_state == S_IDLE) & w_is_m & ~flush_i;

    assign w_sa = op1_i[31] & ((w_f3 == 3'd1) | (w_f3 == 3'd2)
                             | (w_f3 == 3'd4) | (w_f3 == 3'd6));
    assign w_sb = op2_i[31] & ((w_f3 == 3'd1) | (w_f3 == 3'd4)
                             | (w_f3 == 3'd6));
    assign w_abs_a = w_sa ? (~op1_i + 32'd1) : op1_i;
    assign w_abs_b = w_sb ? (~op2_i + 32'd1) : op2_i;
    assign w_dz = w_f3[2] & (op2_i == 32'd0);

    // Multiply: add multiplicand into the high half, then shift right.
    assign w_mul_sum = {1'b0, r_acc[63:32]}
                     + (r_acc[0] ? {1'b0, r_b} : 33'd0);
    assign w_mul_next = {w_mul_sum, r_acc[31:1]};

    // Divide: remainder in the high half, quotient bits enter at the bottom.
    assign w_div_hi = r_acc[63:31];
    assign w_div_ge = (w_div_hi >= {1'b0, r_b});
    assign w_div_sub = w_div_hi[31:0] - r_b;
    assign w_div_next = w_div_ge
                      ? {w_div_sub, r_acc[30:0], 1'b1}
                      : {w_div_hi[31:0], r_acc[30:0], 1'b0};

    assign w_p = r_neg ? (~r_acc + 64'd1) : r_acc;
    assign w_q = r_neg ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
    assign w_r = r_negr ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];

    // Final result selection by operation.
    always_comb begin
        w_res = 32'd0;
        case (r_f3)
            3'd0:    w_res = w_p[31:0];
            3'd1,
            3'd2,
            3'd3:    w_res = w_p[63:32];
            3'd4,
            3'd5:    w_res = w_q;
            default: w_res = w_r;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_nxt;
    end

    // Next-state logic; flush always returns to IDLE.
    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (w_accept) w_nxt = w_dz ? S_DONE : S_BUSY;
            S_BUSY: if (r_cnt == 5'd31) w_nxt = S_DONE;
            S_DONE: w_nxt = S_IDLE;
            default: w_nxt = S_IDLE;
        endcase
        if (flush_i) w_nxt = S_IDLE;
    end

    // Operand capture and iteration datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_f3   <= 3'd0;
            r_rd   <= 5'd0;
            r_b    <= 32'd0;
            r_neg  <= 1'b0;
            r_negr <= 1'b0;
            r_acc  <= 64'd0;
            r_cnt  <= 5'd0;
        end else if (w_accept) begin
            r_f3   <= w_f3;
            r_rd   <= rd_addr_i;
            r_b    <= w_abs_b;
            r_neg  <= ~w_dz & (w_sa ^ w_sb);
            r_negr <= ~w_dz & w_sa;
            r_acc  <= w_dz ? {op1_i, 32'hFFFF_FFFF}
                           : {32'd0, w_abs_a};
            r_cnt  <= 5'd0;
        end else if (flush_i) begin
            r_cnt  <= 5'd0;
        end else if (r_state == S_BUSY) begin
            r_cnt  <= r_cnt + 5'd1;
            r_acc  <= r_f3[2] ? w_div_next : w_mul_next;
        end
    end

    // Outputs: result only in DONE, stall while accepting or iterating.
    always_comb begin
        rd_data_o = 32'd0;
        rd_addr_o = 5'd0;
        reg_wen_o = 1'b0;
        hold_o    = w_accept | ((r_state == S_BUSY) & ~flush_i);
        busy_o    = (r_state == S_BUSY) | (r_state == S_DONE);
        if (r_state == S_DONE) begin
            rd_data_o = w_res;
            rd_addr_o = r_rd;
            reg_wen_o = ~flush_i;
        end
    end

endmodule
